pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1; one clock, reset asynchronous and active-low.
REQ-003 SHALL have imem_read, imem_resp, inputs, 1 each: IF fetch outstanding and instruction cache response.
REQ-004 SHALL have dmem_read, dmem_write, dmem_resp, inputs, 1 each: MEM-stage access and data cache response.
REQ-005 SHALL have id_rs1, id_rs2, inputs, 5 each: source registers of the instruction in ID.
REQ-006 SHALL have ex_rd, input, 5, and ex_is_load, input, 1: destination and load flag of the instruction in EX (ex_is_load implies load_regfile).
REQ-007 SHALL have ex_valid, input, 1, and pcmux_sel, input, 2: EX holds a real instruction; EX next-PC select (0 = pc+4).
REQ-008 SHALL have load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, outputs, 1 each: register/buffer enables.
REQ-009 SHALL have flush_if_id, flush_id_ex, outputs, 1 each: replace buffer contents with a bubble on the enabled edge.
REQ-010 SHALL have stall_cycles, bubble_count, flush_count, outputs, 32 each: performance counters.

Function
REQ-011 SHALL keep a 2-bit state register with states RUN, MEM_STALL, BUBBLE.
REQ-012 SHALL define mem_stall = (imem_read & ~imem_resp) | ((dmem_read | dmem_write) & ~dmem_resp).
REQ-013 SHALL define taken = ex_valid & (pcmux_sel != 0).
REQ-014 SHALL define load_use = ex_valid & ex_is_load & (ex_rd != 0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2)), masked to 0 while state is BUBBLE.
REQ-015 SHALL prioritise mem_stall > taken > load_use; all enable/flush outputs combinational, same cycle.
REQ-016 SHALL, on mem_stall, drive all five load_* 0 and both flush_* 0 (whole pipeline frozen).
REQ-017 SHALL, on taken without mem_stall, drive all load_* 1 and flush_if_id = flush_id_ex = 1.
REQ-018 SHALL, on load_use without mem_stall/taken, drive load_pc = load_if_id = 0, load_id_ex = load_ex_mem = load_mem_wb = 1, flush_id_ex = 1, flush_if_id = 0 (one bubble).
REQ-019 SHALL otherwise drive all load_* 1, all flush_* 0.
REQ-020 SHALL transition: any state -> MEM_STALL when mem_stall; else -> BUBBLE when load_use; else -> RUN.
REQ-021 SHALL, in MEM_STALL, retain a taken/load_use condition present during the stall and act on it on the first non-stalled cycle (inputs held stable by freeze).
REQ-022 SHALL mask load_use in BUBBLE for exactly one cycle; a second consecutive load_use is impossible by construction and SHALL NOT produce a second bubble.
REQ-023 SHALL increment stall_cycles each cycle mem_stall = 1, bubble_count each cycle REQ-018 applies, flush_count each cycle REQ-017 applies.
REQ-024 SHALL saturate each counter at 32'hFFFF_FFFF (no wrap).
REQ-025 SHALL treat rd = x0 as never hazarding; branch and load-use in the same cycle SHALL yield flush only (bubble_count unchanged).

Reset
REQ-026 SHALL, while rst = 0, force state = RUN and all counters = 0, asynchronously.
REQ-027 SHALL, during reset, drive all load_* 0 and all flush_* 0 regardless of inputs.
REQ-028 SHALL, on reset deassertion mid-stall, start in RUN and re-evaluate inputs from the first edge.

Verification
REQ-029 SHALL cover: ex_is_load=1, ex_rd=5, id_rs2=5, no stall -> one cycle load_pc=0, load_if_id=0, flush_id_ex=1; bubble_count=1; next cycle all loads 1.
REQ-030 SHALL cover: dmem_read=1, dmem_resp=0 for 4 cycles then 1 -> loads 0 for 4 cycles, stall_cycles=4, state MEM_STALL then RUN.
REQ-031 SHALL cover: ex_valid=1, pcmux_sel=1 with load_use also true -> flush_if_id=flush_id_ex=1, flush_count=1, bubble_count=0.
REQ-032 SHALL cover: taken held during 3-cycle imem stall -> no flush for 3 cycles, flush on cycle 4, flush_count=1.
REQ-033 SHALL cover: ex_rd=0, ex_is_load=1, id_rs1=0 -> no bubble.
REQ-034 SHALL cover: stall_cycles preloaded near 32'hFFFF_FFFE, 3 stall cycles -> holds 32'hFFFF_FFFF; rst pulse low -> all counters 0 immediately.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller for a 5-stage in-order pipeline.
// Decides per cycle whether the pipeline advances, freezes on a cache miss,
// flushes on a taken branch/jump, or inserts one bubble on a load-use hazard.
// Also keeps saturating performance counters for stalls, bubbles and flushes.
module pipeline_hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_read,
    input  logic        imem_resp,
    input  logic        dmem_read,
    input  logic        dmem_write,
    input  logic        dmem_resp,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_is_load,
    input  logic        ex_valid,
    input  logic [1:0]  pcmux_sel,
    output logic        load_pc,
    output logic        load_if_id,
    output logic        load_id_ex,
    output logic        load_ex_mem,
    output logic        load_mem_wb,
    output logic        flush_if_id,
    output logic        flush_id_ex,
    output logic [31:0] stall_cycles,
    output logic [31:0] bubble_count,
    output logic [31:0] flush_count
);

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_MEM_STALL = 2'd1,
        ST_BUBBLE    = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        pend_taken_q, pend_taken_d;
    logic        pend_lu_q, pend_lu_d;
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] bubble_count_q, bubble_count_d;
    logic [31:0] flush_count_q, flush_count_d;

    logic        mem_stall_s;
    logic        taken_raw_s;
    logic        lu_raw_s;
    logic        in_stall_s;
    logic        taken_s;
    logic        lu_s;
    logic        do_flush_s;
    logic        do_bubble_s;

    // Counters stop at all-ones rather than wrapping back to zero.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        logic [31:0] r;
        if (en && (v != 32'hFFFF_FFFF)) begin
            r = v + 32'd1;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Hazard detection; pending conditions captured during a freeze are
    // replayed on the first cycle the memory system releases the pipeline.
    always_comb begin
        mem_stall_s = (imem_read & ~imem_resp) | ((dmem_read | dmem_write) & ~dmem_resp);
        taken_raw_s = ex_valid & (pcmux_sel != 2'd0);
        lu_raw_s    = ex_valid & ex_is_load & (ex_rd != 5'd0)
                      & ((ex_rd == id_rs1) | (ex_rd == id_rs2))
                      & (state_q != ST_BUBBLE);
        in_stall_s  = (state_q == ST_MEM_STALL);
        taken_s     = taken_raw_s | (in_stall_s & pend_taken_q);
        lu_s        = lu_raw_s | (in_stall_s & pend_lu_q);
        do_flush_s  = ~mem_stall_s & taken_s;
        do_bubble_s = ~mem_stall_s & ~taken_s & lu_s;
    end

    // Enable/flush decode with priority stall > flush > bubble; all quiet in reset.
    always_comb begin
        load_pc     = 1'b0;
        load_if_id  = 1'b0;
        load_id_ex  = 1'b0;
        load_ex_mem = 1'b0;
        load_mem_wb = 1'b0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        if (!rst) begin
            load_pc = 1'b0;
        end else if (mem_stall_s) begin
            load_pc = 1'b0;
        end else if (taken_s) begin
            load_pc     = 1'b1;
            load_if_id  = 1'b1;
            load_id_ex  = 1'b1;
            load_ex_mem = 1'b1;
            load_mem_wb = 1'b1;
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end else if (lu_s) begin
            load_id_ex  = 1'b1;
            load_ex_mem = 1'b1;
            load_mem_wb = 1'b1;
            flush_id_ex = 1'b1;
        end else begin
            load_pc     = 1'b1;
            load_if_id  = 1'b1;
            load_id_ex  = 1'b1;
            load_ex_mem = 1'b1;
            load_mem_wb = 1'b1;
        end
    end

    // Next-state, pending-condition and counter update logic.
    always_comb begin
        state_d        = ST_RUN;
        pend_taken_d   = 1'b0;
        pend_lu_d      = 1'b0;
        if (mem_stall_s) begin
            state_d      = ST_MEM_STALL;
            pend_taken_d = (in_stall_s & pend_taken_q) | taken_raw_s;
            pend_lu_d    = (in_stall_s & pend_lu_q) | lu_raw_s;
        end else if (lu_s) begin
            state_d = ST_BUBBLE;
        end else begin
            state_d = ST_RUN;
        end
        stall_cycles_d = sat_inc(stall_cycles_q, mem_stall_s);
        bubble_count_d = sat_inc(bubble_count_q, do_bubble_s);
        flush_count_d  = sat_inc(flush_count_q, do_flush_s);
    end

    // State and counter registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_RUN;
            pend_taken_q   <= 1'b0;
            pend_lu_q      <= 1'b0;
            stall_cycles_q <= 32'd0;
            bubble_count_q <= 32'd0;
            flush_count_q  <= 32'd0;
        end else begin
            state_q        <= state_d;
            pend_taken_q   <= pend_taken_d;
            pend_lu_q      <= pend_lu_d;
            stall_cycles_q <= stall_cycles_d;
            bubble_count_q <= bubble_count_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign bubble_count = bubble_count_q;
    assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios with
// literal expectations, then randomized traffic against a rule-level model.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_read, imem_resp, dmem_read, dmem_write, dmem_resp;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        ex_is_load, ex_valid;
    logic [1:0]  pcmux_sel;
    logic        load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
    logic        flush_if_id, flush_id_ex;
    logic [31:0] stall_cycles, bubble_count, flush_count;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic        m_in_stall, m_pend_tk, m_pend_lu, m_mask;
    logic [31:0] m_stall, m_bub, m_flush;

    wire [6:0] obs = {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
                      flush_if_id, flush_id_ex};

    localparam logic [6:0] O_FROZEN = 7'b0000000;
    localparam logic [6:0] O_FLUSH  = 7'b1111111;
    localparam logic [6:0] O_BUBBLE = 7'b0011101;
    localparam logic [6:0] O_NORMAL = 7'b1111100;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .imem_read(imem_read), .imem_resp(imem_resp),
        .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_resp(dmem_resp),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
        .ex_is_load(ex_is_load), .ex_valid(ex_valid), .pcmux_sel(pcmux_sel),
        .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
        .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .stall_cycles(stall_cycles), .bubble_count(bubble_count),
        .flush_count(flush_count)
    );

    function automatic logic m_ms();
        return (imem_read & ~imem_resp) | ((dmem_read | dmem_write) & ~dmem_resp);
    endfunction

    function automatic logic m_tk_raw();
        return ex_valid && (pcmux_sel != 2'd0);
    endfunction

    function automatic logic m_lu_raw();
        return !m_mask && ex_valid && ex_is_load && (ex_rd != 5'd0) &&
               ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    endfunction

    function automatic logic [6:0] model_expect();
        logic tk, lu;
        tk = m_tk_raw() || (m_in_stall && m_pend_tk);
        lu = m_lu_raw() || (m_in_stall && m_pend_lu);
        if (!rst)        return O_FROZEN;
        else if (m_ms()) return O_FROZEN;
        else if (tk)     return O_FLUSH;
        else if (lu)     return O_BUBBLE;
        else             return O_NORMAL;
    endfunction

    task automatic model_reset();
        m_in_stall = 1'b0; m_pend_tk = 1'b0; m_pend_lu = 1'b0; m_mask = 1'b0;
        m_stall = 32'd0; m_bub = 32'd0; m_flush = 32'd0;
    endtask

    // Advance the model by one clock edge from the current inputs.
    task automatic model_step();
        logic ms, tkr, lur, tk, lu;
        ms  = m_ms();
        tkr = m_tk_raw();
        lur = m_lu_raw();
        tk  = tkr || (m_in_stall && m_pend_tk);
        lu  = lur || (m_in_stall && m_pend_lu);
        if (ms) begin
            if (m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
        end else if (tk) begin
            if (m_flush != 32'hFFFF_FFFF) m_flush = m_flush + 32'd1;
        end else if (lu) begin
            if (m_bub != 32'hFFFF_FFFF) m_bub = m_bub + 32'd1;
        end
        if (ms) begin
            m_pend_tk = (m_in_stall && m_pend_tk) || tkr;
            m_pend_lu = (m_in_stall && m_pend_lu) || lur;
        end else begin
            m_pend_tk = 1'b0;
            m_pend_lu = 1'b0;
        end
        m_mask     = !ms && lu;
        m_in_stall = ms;
    endtask

    task automatic tick();
        model_step();
        @(negedge clk);
    endtask

    task automatic set_idle();
        imem_read = 1'b0; imem_resp = 1'b0; dmem_read = 1'b0; dmem_write = 1'b0;
        dmem_resp = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        ex_is_load = 1'b0; ex_valid = 1'b0; pcmux_sel = 2'd0;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        model_reset();
        imem_read = 1'b0; imem_resp = 1'b1; dmem_read = 1'b0; dmem_write = 1'b0;
        dmem_resp = 1'b1; ex_valid = 1'b1; pcmux_sel = 2'd1; ex_is_load = 1'b1;
        ex_rd = 5'd3; id_rs1 = 5'd3; id_rs2 = 5'd0;
        #1;
        checks++;
        if (obs !== O_FROZEN) begin
            failures++; $display("FAIL reset_outputs: got %b expected %b", obs, O_FROZEN);
        end
        @(negedge clk);
        checks++;
        if ({stall_cycles, bubble_count, flush_count} !== 96'd0) begin
            failures++; $display("FAIL reset_counters: got %h %h %h expected 0",
                                 stall_cycles, bubble_count, flush_count);
        end
        rst = 1'b1;
        set_idle();
        #1;
        checks++;
        if (obs !== O_NORMAL) begin
            failures++; $display("FAIL reset_release: got %b expected %b", obs, O_NORMAL);
        end
        @(negedge clk);
    endtask

    task automatic test_load_use();
        do_reset();
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5;
        id_rs1 = 5'($urandom_range(6, 31));
        #1;
        checks++;
        if (obs !== O_BUBBLE) begin
            failures++; $display("FAIL load_use_bubble: got %b expected %b", obs, O_BUBBLE);
        end
        tick();
        checks++;
        if (bubble_count !== 32'd1) begin
            failures++; $display("FAIL load_use_count: got %0d expected 1", bubble_count);
        end
        #1;
        checks++;
        if (obs !== O_NORMAL) begin
            failures++; $display("FAIL load_use_no_second: got %b expected %b", obs, O_NORMAL);
        end
        tick();
        checks++;
        if (bubble_count !== 32'd1) begin
            failures++; $display("FAIL load_use_count2: got %0d expected 1", bubble_count);
        end
        set_idle();
    endtask

    task automatic test_mem_stall();
        do_reset();
        dmem_read = 1'b1; dmem_resp = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (obs !== O_FROZEN) begin
                failures++; $display("FAIL mem_stall_frozen[%0d]: got %b expected %b", i, obs, O_FROZEN);
            end
            tick();
        end
        checks++;
        if (stall_cycles !== 32'd4) begin
            failures++; $display("FAIL mem_stall_count: got %0d expected 4", stall_cycles);
        end
        dmem_resp = 1'b1;
        #1;
        checks++;
        if (obs !== O_NORMAL) begin
            failures++; $display("FAIL mem_stall_release: got %b expected %b", obs, O_NORMAL);
        end
        tick();
        checks++;
        if (stall_cycles !== 32'd4) begin
            failures++; $display("FAIL mem_stall_count_hold: got %0d expected 4", stall_cycles);
        end
        set_idle();
    endtask

    task automatic test_branch_over_load_use();
        do_reset();
        ex_valid = 1'b1; pcmux_sel = 2'($urandom_range(1, 3));
        ex_is_load = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7;
        #1;
        checks++;
        if (obs !== O_FLUSH) begin
            failures++; $display("FAIL branch_lu_flush: got %b expected %b", obs, O_FLUSH);
        end
        tick();
        checks++;
        if (flush_count !== 32'd1 || bubble_count !== 32'd0) begin
            failures++; $display("FAIL branch_lu_counts: got flush=%0d bubble=%0d expected 1 0",
                                 flush_count, bubble_count);
        end
        set_idle();
    endtask

    task automatic test_taken_during_stall();
        do_reset();
        imem_read = 1'b1; imem_resp = 1'b0; ex_valid = 1'b1; pcmux_sel = 2'd2;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (obs !== O_FROZEN) begin
                failures++; $display("FAIL taken_stall_frozen[%0d]: got %b expected %b", i, obs, O_FROZEN);
            end
            tick();
        end
        imem_resp = 1'b1;
        #1;
        checks++;
        if (obs !== O_FLUSH) begin
            failures++; $display("FAIL taken_stall_flush: got %b expected %b", obs, O_FLUSH);
        end
        tick();
        checks++;
        if (flush_count !== 32'd1 || stall_cycles !== 32'd3) begin
            failures++; $display("FAIL taken_stall_counts: got flush=%0d stall=%0d expected 1 3",
                                 flush_count, stall_cycles);
        end
        set_idle();
    endtask

    task automatic test_x0();
        do_reset();
        ex_valid = 1'b1; ex_is_load = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0;
        id_rs2 = 5'($urandom_range(0, 31));
        #1;
        checks++;
        if (obs !== O_NORMAL) begin
            failures++; $display("FAIL x0_no_bubble: got %b expected %b", obs, O_NORMAL);
        end
        tick();
        checks++;
        if (bubble_count !== 32'd0) begin
            failures++; $display("FAIL x0_count: got %0d expected 0", bubble_count);
        end
        set_idle();
    endtask

    task automatic test_saturation();
        do_reset();
        force dut.stall_cycles_q = 32'hFFFF_FFFE;
        @(posedge clk);
        #1;
        release dut.stall_cycles_q;
        @(negedge clk);
        m_stall = 32'hFFFF_FFFE;
        checks++;
        if (stall_cycles !== 32'hFFFF_FFFE) begin
            failures++; $display("FAIL sat_preload: got %h expected fffffffe", stall_cycles);
        end
        dmem_write = 1'b1; dmem_resp = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (stall_cycles !== 32'hFFFF_FFFF) begin
            failures++; $display("FAIL sat_hold: got %h expected ffffffff", stall_cycles);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({stall_cycles, bubble_count, flush_count} !== 96'd0 || obs !== O_FROZEN) begin
            failures++; $display("FAIL sat_async_reset: got %h %h %h %b expected 0",
                                 stall_cycles, bubble_count, flush_count, obs);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== O_FROZEN) begin
            failures++; $display("FAIL reset_mid_stall_out: got %b expected %b", obs, O_FROZEN);
        end
        tick();
        checks++;
        if (stall_cycles !== 32'd1) begin
            failures++; $display("FAIL reset_mid_stall_count: got %0d expected 1", stall_cycles);
        end
        set_idle();
    endtask

    task automatic test_random();
        logic [6:0] exp_o;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            imem_read  = 1'($urandom_range(0, 1));
            imem_resp  = ($urandom_range(0, 3) != 0);
            dmem_read  = ($urandom_range(0, 3) == 0);
            dmem_write = ($urandom_range(0, 5) == 0);
            dmem_resp  = ($urandom_range(0, 2) != 0);
            id_rs1     = 5'($urandom_range(0, 3));
            id_rs2     = 5'($urandom_range(0, 3));
            ex_rd      = 5'($urandom_range(0, 3));
            ex_is_load = 1'($urandom_range(0, 1));
            ex_valid   = ($urandom_range(0, 4) != 0);
            pcmux_sel  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            #1;
            exp_o = model_expect();
            checks++;
            if (obs !== exp_o) begin
                failures++; $display("FAIL rand_outputs[%0d]: got %b expected %b", n, obs, exp_o);
            end
            tick();
            checks++;
            if (stall_cycles !== m_stall || bubble_count !== m_bub || flush_count !== m_flush) begin
                failures++; $display("FAIL rand_counters[%0d]: got %0d %0d %0d expected %0d %0d %0d",
                                     n, stall_cycles, bubble_count, flush_count,
                                     m_stall, m_bub, m_flush);
            end
        end
        set_idle();
    endtask

    initial begin
        set_idle();
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_load_use();
        test_mem_stall();
        test_branch_over_load_use();
        test_taken_during_stall();
        test_x0();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
